fifo_burst_reader: RTL

Read-side controller for the synchronous FIFO. On a `start` command it drains exactly `burst_len` words from the FIFO read port and presents them on a valid/ready stream. It absorbs the FIFO's one-cycle registered read latency and sink back-pressure with a 2-entry output buffer, and sustains one word per cycle when the FIFO is non-empty and the sink is ready. It sits between the FIFO and any downstream consumer, such as a serializer or checker.

---
 rtl/fifo_burst_reader.sv | 118 +++++++++++
 1 files changed

// File: rtl/fifo_burst_reader.sv
// rtl/fifo_burst_reader.sv - drains burst_len words from a registered-read FIFO onto a valid/ready stream
module fifo_burst_reader #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  burst_len,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  xfer_count,
    output logic              fifo_rd,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DONE_S = 2'd2
    } state_t;

    state_t            state;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  issued;
    logic [1:0]        occ;
    logic [1:0]        occ_next;
    logic              inflight;
    logic [DATA_W-1:0] tail_q;
    logic              pop;
    logic              credit_ok;

    assign pop = m_valid && m_ready;

    // A read is allowed only if its word is guaranteed a buffer slot when it lands.
    assign credit_ok = ({1'b0, occ} + {2'b00, inflight}) <= (3'd1 + {2'b00, pop});
    assign fifo_rd   = (state == RUN) && !fifo_empty && (issued < len_q) && credit_ok;

    always_comb begin
        occ_next = occ;
        case ({inflight, pop})
            2'b10:   occ_next = occ + 2'd1;
            2'b01:   occ_next = occ - 2'd1;
            default: occ_next = occ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            len_q      <= '0;
            issued     <= '0;
            xfer_count <= '0;
            occ        <= 2'd0;
            inflight   <= 1'b0;
            m_valid    <= 1'b0;
            m_data     <= '0;
            tail_q     <= '0;
        end else begin
            inflight <= fifo_rd;
            occ      <= occ_next;
            m_valid  <= (occ_next != 2'd0);

            // m_data is the buffer head, tail_q the second entry.
            if (inflight && ((occ == 2'd0) || ((occ == 2'd1) && pop)))
                m_data <= fifo_data;
            else if (pop && (occ == 2'd2))
                m_data <= tail_q;

            if (inflight && (((occ == 2'd1) && !pop) || (occ == 2'd2)))
                tail_q <= fifo_data;

            if (fifo_rd)
                issued <= issued + LEN_W'(1);
            if (pop)
                xfer_count <= xfer_count + LEN_W'(1);

            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        len_q      <= burst_len;
                        issued     <= '0;
                        xfer_count <= '0;
                        if (burst_len == '0) begin
                            state <= DONE_S;
                            done  <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (pop && ((xfer_count + LEN_W'(1)) == len_q)) begin
                        state <= DONE_S;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE_S: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
